// File: rtl/render_command_queue_if.sv
// rtl/render_command_queue_if.sv - host write side and renderer read side of the frame-committed command queue
interface render_command_queue_if #(
  parameter int ADDR_WIDTH = 9
);
  logic [7:0]          i_write_data;
  logic                i_write_valid;
  logic                i_write_last;
  logic                i_write_abort;
  logic                o_write_ready;
  logic                o_overflow;
  logic                i_queue_request;
  logic [7:0]          o_queue_data;
  logic                o_queue_data_valid;
  logic                o_queue_eof;
  logic [ADDR_WIDTH:0] o_frames_pending;

  modport master (
    output i_write_data, i_write_valid, i_write_last, i_write_abort, i_queue_request,
    input  o_write_ready, o_overflow, o_queue_data, o_queue_data_valid, o_queue_eof,
           o_frames_pending
  );

  modport slave (
    input  i_write_data, i_write_valid, i_write_last, i_write_abort, i_queue_request,
    output o_write_ready, o_overflow, o_queue_data, o_queue_data_valid, o_queue_eof,
           o_frames_pending
  );
endinterface

// File: rtl/render_command_queue.sv
// rtl/render_command_queue.sv - byte FIFO that only exposes fully committed command lists to the renderer
module render_command_queue #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  i_master_clk,
  input  logic                  i_reset_n,
  render_command_queue_if.slave bus
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  typedef enum logic {ST_IDLE, ST_SERVE} state_t;

  state_t        state;
  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] used;
  logic          eof_pending;
  logic          full;
  logic          wr_fire;
  logic          commit_fire;
  logic          serve;
  logic          do_eof;
  logic          do_read;

  assign used          = wr_ptr - rd_ptr;
  assign full          = (used == FULL_CNT);
  assign bus.o_write_ready = !full;
  assign wr_fire       = bus.i_write_valid && !full && !bus.i_write_abort;
  assign commit_fire   = wr_fire && bus.i_write_last;

  // A fresh request is served in the cycle it arrives; SERVE only holds a request waiting for a commit.
  assign serve   = (state == ST_SERVE) || bus.i_queue_request;
  assign do_eof  = serve && eof_pending;
  assign do_read = serve && !eof_pending && (commit_ptr != rd_ptr);

  always_ff @(posedge i_master_clk) begin
    if (wr_fire) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {bus.i_write_last, bus.i_write_data};
    end
  end

  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      bus.o_overflow <= 1'b0;
    end else if (bus.i_write_abort) begin
      wr_ptr         <= commit_ptr;
      bus.o_overflow <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + ONE;
        if (bus.i_write_last) begin
          commit_ptr <= wr_ptr + ONE;
        end
      end
      // Storage full of one uncommitted list: only an abort can make progress.
      if (full && (commit_ptr == rd_ptr) && !eof_pending) begin
        bus.o_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state                  <= ST_IDLE;
      rd_ptr                 <= '0;
      eof_pending            <= 1'b0;
      bus.o_queue_data       <= '0;
      bus.o_queue_data_valid <= 1'b0;
      bus.o_queue_eof        <= 1'b0;
      bus.o_frames_pending   <= '0;
    end else begin
      bus.o_queue_data_valid <= do_read;
      bus.o_queue_eof        <= do_eof;
      if (do_eof) begin
        eof_pending <= 1'b0;
      end
      if (do_read) begin
        bus.o_queue_data <= mem[rd_ptr[ADDR_WIDTH-1:0]][7:0];
        eof_pending      <= mem[rd_ptr[ADDR_WIDTH-1:0]][8];
        rd_ptr           <= rd_ptr + ONE;
      end
      case (state)
        ST_IDLE:  if (bus.i_queue_request && !do_eof && !do_read) state <= ST_SERVE;
        ST_SERVE: if (do_eof || do_read) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
      case ({commit_fire, do_eof})
        2'b10:   bus.o_frames_pending <= bus.o_frames_pending + ONE;
        2'b01:   bus.o_frames_pending <= bus.o_frames_pending - ONE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_render_command_queue.sv
// tb/tb_render_command_queue.sv - scoreboard bench for render_command_queue with a list-level reference model
module tb_render_command_queue;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  render_command_queue_if #(.ADDR_WIDTH(AW)) bus();

  render_command_queue #(.ADDR_WIDTH(AW)) dut (
    .i_master_clk (clk),
    .i_reset_n    (rst_n),
    .bus          (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: expected renderer responses ({is_eof, byte}), the open partial list,
  // bytes occupying storage, committed-but-unterminated lists, and the outstanding request.
  logic [8:0] sb[$];
  logic [7:0] part[$];
  int         stored;
  int         frames;
  bit         pend;
  int         deadline;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    part.delete();
    stored   = 0;
    frames   = 0;
    pend     = 1'b0;
    deadline = -1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      logic [8:0] exp_item;
      logic [8:0] got_item;
      if (bus.o_queue_data_valid || bus.o_queue_eof) begin
        check("single_pulse_kind", int'(bus.o_queue_data_valid && bus.o_queue_eof), 0);
        check("resp_expected", int'(pend), 1);
        if (pend) check("resp_latency", cyc, deadline);
        pend     = 1'b0;
        deadline = -1;
        check("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_item = sb.pop_front();
          got_item = bus.o_queue_eof ? 9'h100 : {1'b0, bus.o_queue_data};
          check("resp_item", int'(got_item), int'(exp_item));
          if (exp_item[8]) frames--;
          else stored--;
        end
      end else if (pend && deadline >= 0 && cyc > deadline) begin
        check("resp_timeout", cyc, deadline);
        pend     = 1'b0;
        deadline = -1;
      end
      check("write_ready", int'(bus.o_write_ready), int'(stored != DEPTH));
      check("frames_pending", int'(bus.o_frames_pending), frames);
    end
  end

  // One cycle of stimulus; the model is updated with what the DUT must do at the coming edge.
  task automatic drive(input bit wv, input logic [7:0] wd, input bit wl, input bit ab, input bit rq);
    @(negedge clk);
    #1;
    if (rq && !pend) begin
      pend     = 1'b1;
      deadline = (sb.size() > 0) ? cyc + 1 : -1;
    end
    if (ab) begin
      stored -= part.size();
      part.delete();
    end else if (wv && stored != DEPTH) begin
      stored++;
      part.push_back(wd);
      if (wl) begin
        foreach (part[i]) sb.push_back({1'b0, part[i]});
        sb.push_back(9'h100);
        part.delete();
        frames++;
        if (pend && deadline < 0) deadline = cyc + 2;
      end
    end
    bus.i_write_valid   = wv;
    bus.i_write_data    = wd;
    bus.i_write_last    = wl;
    bus.i_write_abort   = ab;
    bus.i_queue_request = rq;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [7:0] d, input bit last);
    drive(1'b1, d, last, 1'b0, 1'b0);
  endtask

  task automatic drain(input int max_pairs);
    for (int i = 0; i < max_pairs; i++) begin
      if (sb.size() == 0 && !pend) break;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      idle(1);
    end
    idle(2);
    check("drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.i_write_valid   = 1'b0;
    bus.i_write_last    = 1'b0;
    bus.i_write_abort   = 1'b0;
    bus.i_queue_request = 1'b0;
    model_clear();
    #1;
    check("rst_data", int'(bus.o_queue_data), 0);
    check("rst_valid", int'(bus.o_queue_data_valid), 0);
    check("rst_eof", int'(bus.o_queue_eof), 0);
    check("rst_frames", int'(bus.o_frames_pending), 0);
    check("rst_overflow", int'(bus.o_overflow), 0);
    check("rst_ready", int'(bus.o_write_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    model_clear();
    rst_n               = 1'b0;
    bus.i_write_data    = 8'h00;
    bus.i_write_valid   = 1'b0;
    bus.i_write_last    = 1'b0;
    bus.i_write_abort   = 1'b0;
    bus.i_queue_request = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();

    // Three-byte list, then four spaced requests: three bytes and an eof.
    wr(8'h01, 1'b0);
    wr(8'h22, 1'b0);
    wr(8'h83, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      idle(1);
    end
    idle(2);
    check("t1_drained", sb.size(), 0);

    // Request waiting on an empty queue, satisfied by a later commit.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(5);
    wr(8'h55, 1'b1);
    idle(3);
    drain(8);

    // Aborted partial list is never seen by the reader.
    wr(8'hAA, 1'b0);
    wr(8'hBB, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    wr(8'hCC, 1'b1);
    drain(8);

    // Fill all storage with one uncommitted list: deadlock flagged, abort recovers.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) wr(8'(i), 1'b0);
    idle(3);
    check("ovf_set", int'(bus.o_overflow), 1);
    check("full_not_ready", int'(bus.o_write_ready), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("ovf_cleared", int'(bus.o_overflow), 0);
    wr(8'h5A, 1'b1);
    drain(8);

    // Two short lists straddling the index 511 -> 0 wrap.
    do_reset();
    for (int i = 0; i < DEPTH - 2; i++) wr(8'(i * 7), i == DEPTH - 3);
    drain(DEPTH + 4);
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b1);
    wr(8'h33, 1'b1);
    idle(1);
    check("wrap_frames", int'(bus.o_frames_pending), 2);
    drain(10);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 6) == 0,
            $urandom_range(0, 60) == 0, $urandom_range(0, 1) == 1);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drain(2 * DEPTH);

    // Reset while a request waits and a four-byte list has just committed.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    wr(8'h91, 1'b0);
    wr(8'h92, 1'b0);
    wr(8'h93, 1'b0);
    wr(8'h94, 1'b1);
    do_reset();
    idle(4);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(3);
    wr(8'h77, 1'b1);
    idle(3);
    drain(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
